// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR display slice: step-mode encodings and the
// active-low seven-segment glyph table used by every hex digit decoder.
package lfsr_pkg;

  // Step mode selected by the mode input.
  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  // Glyphs 0-F, segment order {a,b,c,d,e,f,g,dp}, a in the MSB, 0 = lit,
  // decimal point always dark. 'b' and 'd' are the lower-case forms.
  localparam logic [7:0] SEG_GLYPH [16] = '{
    8'h03,  // 0
    8'h9F,  // 1
    8'h25,  // 2
    8'h0D,  // 3
    8'h99,  // 4
    8'h49,  // 5
    8'h41,  // 6
    8'h1F,  // 7
    8'h01,  // 8
    8'h09,  // 9
    8'h11,  // A
    8'hC1,  // b
    8'h63,  // C
    8'h85,  // d
    8'h61,  // E
    8'h71   // F
  };

endpackage

// File: rtl/hex7seg.sv
// One hex digit to active-low seven-segment decoder.
module hex7seg
  import lfsr_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  // Look up the glyph for the nibble; every code has an explicit arm.
  always_comb begin
    case (digit)
      4'h0:    seg = SEG_GLYPH[0];
      4'h1:    seg = SEG_GLYPH[1];
      4'h2:    seg = SEG_GLYPH[2];
      4'h3:    seg = SEG_GLYPH[3];
      4'h4:    seg = SEG_GLYPH[4];
      4'h5:    seg = SEG_GLYPH[5];
      4'h6:    seg = SEG_GLYPH[6];
      4'h7:    seg = SEG_GLYPH[7];
      4'h8:    seg = SEG_GLYPH[8];
      4'h9:    seg = SEG_GLYPH[9];
      4'hA:    seg = SEG_GLYPH[10];
      4'hB:    seg = SEG_GLYPH[11];
      4'hC:    seg = SEG_GLYPH[12];
      4'hD:    seg = SEG_GLYPH[13];
      4'hE:    seg = SEG_GLYPH[14];
      4'hF:    seg = SEG_GLYPH[15];
      // NOTE: a default arm (even if unreachable) keeps the combinational output assigned on every path, so no latch is inferred.
      default: seg = 8'hFF;
    endcase
  end

endmodule

// File: rtl/lfsr_seg.sv
// Fibonacci/Galois LFSR with cycle-length measurement and a hex display of
// the current register on active-low seven-segment digits.
module lfsr_seg
  import lfsr_pkg::*;
#(
  parameter  int               WIDTH = 8,
  parameter  logic [WIDTH-1:0] TAPS  = WIDTH'(8'h1D),
  localparam int               NDIG  = (WIDTH + 3) / 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    seed,
  input  logic                load,
  input  logic                en,
  input  logic                mode,
  output logic [WIDTH-1:0]    state,
  output logic [NDIG*8-1:0]   hex,
  output logic                lockup,
  output logic [WIDTH-1:0]    period,
  output logic                period_vld
);

  logic [WIDTH-1:0]  ref_q;      // state the current measurement started from
  logic [WIDTH-1:0]  cnt_q;      // steps taken since ref_q was last seen
  logic [WIDTH-1:0]  nxt;        // state after one step in the selected mode
  logic [WIDTH-1:0]  cnt_inc;    // saturating cnt_q + 1
  logic [NDIG*4-1:0] state_pad;  // state widened to whole nibbles

  assign lockup = (state == '0);

  // Next state for one step; mode is sampled every step so it may change mid-run.
  always_comb begin
    nxt = {^(state & TAPS), state[WIDTH-1:1]};
    if (mode == LFSR_GAL) begin
      nxt = (state >> 1) ^ (state[0] ? TAPS : '0);
    end
  end

  // Step counter advance, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
  end

  // Register update with priority rst > load > en; no request holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state      <= WIDTH'(1);
      ref_q      <= WIDTH'(1);
      cnt_q      <= '0;
      period     <= '0;
      period_vld <= 1'b0;
    end else if (load) begin
      state      <= seed;
      ref_q      <= seed;
      cnt_q      <= '0;
      period_vld <= 1'b0;
    end else if (en) begin
      state <= nxt;
      // The all-zero state trivially "returns" to itself; that is a lockup,
      // not a cycle, so it never produces a measurement.
      if ((nxt == ref_q) && !lockup) begin
        period     <= cnt_inc;
        period_vld <= 1'b1;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_inc;
      end
    end
  end

  // Zero-extend state so the top digit reads missing high bits as 0.
  always_comb begin
    state_pad               = '0;
    state_pad[WIDTH-1:0]    = state;
  end

  for (genvar i = 0; i < NDIG; i++) begin : g_digit
    hex7seg u_hex7seg (
      .digit (state_pad[4*i +: 4]),
      .seg   (hex[8*i +: 8])
    );
  end

endmodule
